// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Shares one UART transmitter between NUM_REQ byte-stream
//             requesters. Round-robin arbitration with packet lock: a granted
//             requester keeps the transmitter until its last-flagged byte has
//             been accepted, or until it is disabled or times out.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int CNT_W        = 16,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [NUM_REQ-1:0]   req_enable,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     bytes_sent
);

    // The lock counter only ever reaches LOCK_TIMEOUT-1 before it is cleared.
    localparam int              c_TO_W      = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    // Reset grant points at the highest requester so requester 0 wins first.
    localparam logic [ID_W-1:0] c_GRANT_RST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_grant;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic                r_hold_last;
    logic                r_busy;
    logic                r_timeout_err;
    logic [CNT_W-1:0]    r_bytes_sent;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                r_tx_ready_q;

    logic [NUM_REQ-1:0]  w_cand;
    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_idx;
    logic [7:0]          w_sel_data;
    logic                w_accept;
    logic                w_to_hit;

    assign w_cand     = req_valid & req_enable;
    assign w_sel_data = req_data[int'(r_grant)*8 +: 8];

    // The transmitter takes the byte when ready falls while start is held;
    // this is true both for a start from IDLE and for a start seen in STOP.
    assign w_accept   = r_tx_start & r_tx_ready_q & ~tx_ready;

    // A zero LOCK_TIMEOUT disables the lock-release timer entirely.
    assign w_to_hit   = (LOCK_TIMEOUT > 0) && (int'(r_to_cnt) == LOCK_TIMEOUT - 1);

    // Round-robin search starting one past the last grant and wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_grant;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_grant) + k) % NUM_REQ);
            if (!w_found && w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Only the locked requester sees ready, and only while a byte is wanted.
    always_comb begin
        req_ready = '0;
        if (r_state == S_FETCH) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    // Controller state machine with registered transmitter-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_ARB;
            r_grant       <= c_GRANT_RST;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_hold_last   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_bytes_sent  <= '0;
            r_to_cnt      <= '0;
            r_tx_ready_q  <= 1'b1;
        end else begin
            r_tx_ready_q  <= tx_ready;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_ARB: begin
                    if (w_found) begin
                        r_grant <= w_winner;
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (req_valid[r_grant]) begin
                        r_tx_data   <= w_sel_data;
                        r_hold_last <= req_last[r_grant];
                        r_to_cnt    <= '0;
                        r_tx_start  <= 1'b1;
                        r_state     <= S_SEND;
                    end else if (!req_enable[r_grant]) begin
                        // Disabled mid-packet: release quietly, nothing taken.
                        r_to_cnt <= '0;
                        r_state  <= S_ARB;
                        r_busy   <= 1'b0;
                    end else if (w_to_hit) begin
                        r_to_cnt      <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_ARB;
                        r_busy        <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end
                S_SEND: begin
                    // Enable changes are ignored here so the byte in flight completes.
                    if (w_accept) begin
                        r_tx_start   <= 1'b0;
                        r_bytes_sent <= r_bytes_sent + CNT_W'(1);
                        if (r_hold_last) begin
                            r_state <= S_ARB;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state    <= S_ARB;
                    r_busy     <= 1'b0;
                    r_tx_start <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign bytes_sent  = r_bytes_sent;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter with a behavioural
//             UART transmitter (IDLE/START/DATA/STOP, tick every 4 clocks)
//             and queue-driven requesters feeding a byte scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 4;

    logic                 clock;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_enable;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 timeout_err;
    logic [CNT_W-1:0]     bytes_sent;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LOCK_TIMEOUT (8),
        .CNT_W        (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_enable  (req_enable),
        .req_ready   (req_ready),
        .tx_ready    (tx_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .bytes_sent  (bytes_sent)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Requester byte queues: {last, data}.
    logic [8:0] rq [NUM_REQ][$];
    // Scoreboard entries: {grant, data}.
    logic [9:0] exp_q [$];
    logic [9:0] obs_q [$];
    int         obs_cyc [$];
    logic [9:0] e, o;

    // Requesters: pop on handshake, then present the next queued byte.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                end
            end
        end
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_data[8*i +: 8]   = rq[i][0][7:0];
                req_last[i]          = rq[i][0][8];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[8*i +: 8]   = 8'h00;
                req_last[i]          = 1'b0;
            end
        end
    end

    // Behavioural transmitter: ready in IDLE and STOP; in STOP a held start
    // is only taken on the tick, giving seamless back-to-back frames.
    localparam logic [1:0] M_IDLE = 2'd0, M_START = 2'd1, M_DATA = 2'd2, M_STOP = 2'd3;
    logic [1:0] m_state;
    logic [2:0] m_bit;
    logic [1:0] tick_cnt;
    int         m_latches = 0;
    int         cyc = 0;
    wire        tick = (tick_cnt == 2'd3);

    assign tx_ready = (m_state == M_IDLE) || (m_state == M_STOP);

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            m_state  <= M_IDLE;
            m_bit    <= 3'd0;
            tick_cnt <= 2'd0;
        end else begin
            tick_cnt <= tick_cnt + 2'd1;
            case (m_state)
                M_IDLE: if (tx_start) begin
                    obs_q.push_back({grant_id, tx_data});
                    obs_cyc.push_back(cyc);
                    m_latches <= m_latches + 1;
                    m_state   <= M_START;
                end
                M_START: if (tick) begin
                    m_state <= M_DATA;
                    m_bit   <= 3'd0;
                end
                M_DATA: if (tick) begin
                    if (m_bit == 3'd7) m_state <= M_STOP;
                    else               m_bit   <= m_bit + 3'd1;
                end
                default: if (tick) begin
                    if (tx_start) begin
                        obs_q.push_back({grant_id, tx_data});
                        obs_cyc.push_back(cyc);
                        m_latches <= m_latches + 1;
                        m_state   <= M_START;
                    end else begin
                        m_state <= M_IDLE;
                    end
                end
            endcase
        end
    end

    // Protocol monitor: counts events that the test tasks later compare.
    int         rdy0_cycles = 0;
    int         to_high     = 0;
    int         stable_viol = 0;
    int         drop_viol   = 0;
    logic       prev_start  = 1'b0;
    logic [7:0] prev_data   = 8'h00;
    int         rise_latch  = 0;

    always @(negedge clock) begin
        if (reset) begin
            prev_start = 1'b0;
        end else begin
            if (req_ready[0]) rdy0_cycles++;
            if (timeout_err)  to_high++;
            if (prev_start && tx_start && tx_data != prev_data) stable_viol++;
            if (!prev_start && tx_start) rise_latch = m_latches;
            if (prev_start && !tx_start && m_latches == rise_latch) drop_viol++;
            prev_start = tx_start;
            prev_data  = tx_data;
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        req_enable  = '1;
        rdy0_cycles = 0;
        to_high     = 0;
        stable_viol = 0;
        drop_viol   = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic bit q_empty(input logic [NUM_REQ-1:0] mask);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i] && rq[i].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Wait until the masked queues are drained and everything is idle.
    task automatic wait_quiet(input logic [NUM_REQ-1:0] mask, input int budget, output bit ok);
        ok = 1'b0;
        repeat (4) @(negedge clock);
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if (!busy && m_state == M_IDLE && q_empty(mask)) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tx_start, tx_data, req_ready} !== 13'h0) begin
            errors++;
            $display("FAIL reset_tx: start/data/ready got %0h, want 0", {tx_start, tx_data, req_ready});
        end
        checks++;
        if (grant_id !== 2'd3 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: grant=%0d busy=%0b terr=%0b, want 3 0 0", grant_id, busy, timeout_err);
        end
        checks++;
        if (bytes_sent !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: bytes_sent=%0d, want 0", bytes_sent);
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        do_reset();
        rq[0].push_back({1'b1, 8'h55});
        exp_q.push_back({2'd0, 8'h55});
        wait_quiet(4'hF, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_done: ok=%0b, want 1", ok); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL single_count: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if (o !== e) begin errors++; $display("FAIL single_byte: got id%0d %02h, want id%0d %02h", o[9:8], o[7:0], e[9:8], e[7:0]); end
        end
        checks++;
        if (rdy0_cycles != 1) begin errors++; $display("FAIL single_ready: ready0 cycles=%0d, want 1", rdy0_cycles); end
        checks++;
        if (bytes_sent !== 4'd1 || grant_id !== 2'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_state: sent=%0d grant=%0d busy=%0b, want 1 0 0", bytes_sent, grant_id, busy);
        end
        checks++;
        if (stable_viol != 0 || drop_viol != 0) begin
            errors++; $display("FAIL single_hold: stable=%0d drop=%0d, want 0 0", stable_viol, drop_viol);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        rq[0].push_back({1'b1, 8'h10}); rq[0].push_back({1'b1, 8'h10});
        rq[1].push_back({1'b1, 8'h11});
        rq[2].push_back({1'b1, 8'h12});
        rq[3].push_back({1'b1, 8'h13});
        exp_q.push_back({2'd0, 8'h10}); exp_q.push_back({2'd1, 8'h11});
        exp_q.push_back({2'd2, 8'h12}); exp_q.push_back({2'd3, 8'h13});
        exp_q.push_back({2'd0, 8'h10});
        wait_quiet(4'hF, 800, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_done: ok=%0b, want 1", ok); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rr_count: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if (o !== e) begin errors++; $display("FAIL rr_byte: got id%0d %02h, want id%0d %02h", o[9:8], o[7:0], e[9:8], e[7:0]); end
        end
        checks++;
        if (bytes_sent !== 4'd5 || to_high != 0) begin
            errors++; $display("FAIL rr_state: sent=%0d terr_cycles=%0d, want 5 0", bytes_sent, to_high);
        end
    endtask

    task automatic test_packet_lock();
        bit ok;
        do_reset();
        rq[1].push_back({1'b0, 8'hA1}); rq[1].push_back({1'b0, 8'hA2}); rq[1].push_back({1'b1, 8'hA3});
        rq[2].push_back({1'b1, 8'hB2});
        exp_q.push_back({2'd1, 8'hA1}); exp_q.push_back({2'd1, 8'hA2});
        exp_q.push_back({2'd1, 8'hA3}); exp_q.push_back({2'd2, 8'hB2});
        wait_quiet(4'hF, 800, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lock_done: ok=%0b, want 1", ok); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL lock_count: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if (o !== e) begin errors++; $display("FAIL lock_byte: got id%0d %02h, want id%0d %02h", o[9:8], o[7:0], e[9:8], e[7:0]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d1, d2;
        do_reset();
        rq[0].push_back({1'b0, 8'hC1}); rq[0].push_back({1'b0, 8'hC2}); rq[0].push_back({1'b1, 8'hC3});
        exp_q.push_back({2'd0, 8'hC1}); exp_q.push_back({2'd0, 8'hC2}); exp_q.push_back({2'd0, 8'hC3});
        wait_quiet(4'hF, 600, ok);
        d1 = -1; d2 = -1;
        if (obs_cyc.size() >= 3) begin
            d1 = obs_cyc[1] - obs_cyc[0];
            d2 = obs_cyc[2] - obs_cyc[1];
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_done: ok=%0b, want 1", ok); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_byte: got id%0d %02h, want id%0d %02h", o[9:8], o[7:0], e[9:8], e[7:0]); end
        end
        checks++;
        if (d2 != 40) begin errors++; $display("FAIL b2b_gap: frame spacing=%0d cycles, want 40", d2); end
        checks++;
        if (d1 < 37 || d1 > 40) begin errors++; $display("FAIL b2b_first_gap: spacing=%0d cycles, want 37..40", d1); end
        checks++;
        if (stable_viol != 0 || drop_viol != 0 || bytes_sent !== 4'd3) begin
            errors++; $display("FAIL b2b_hold: stable=%0d drop=%0d sent=%0d, want 0 0 3", stable_viol, drop_viol, bytes_sent);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        rq[0].push_back({1'b0, 8'h01});
        rq[3].push_back({1'b1, 8'h33});
        exp_q.push_back({2'd0, 8'h01}); exp_q.push_back({2'd3, 8'h33});
        wait_quiet(4'hF, 600, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_done: ok=%0b, want 1", ok); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL timeout_count: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if (o !== e) begin errors++; $display("FAIL timeout_byte: got id%0d %02h, want id%0d %02h", o[9:8], o[7:0], e[9:8], e[7:0]); end
        end
        checks++;
        if (to_high != 1) begin errors++; $display("FAIL timeout_pulse: terr high cycles=%0d, want 1", to_high); end
        checks++;
        if (rdy0_cycles != 9) begin errors++; $display("FAIL timeout_fetch: ready0 cycles=%0d, want 9", rdy0_cycles); end
        checks++;
        if (bytes_sent !== 4'd2 || grant_id !== 2'd3) begin
            errors++; $display("FAIL timeout_state: sent=%0d grant=%0d, want 2 3", bytes_sent, grant_id);
        end
    endtask

    task automatic test_reset_mid_send();
        bit found;
        do_reset();
        rq[0].push_back({1'b1, 8'h77});
        exp_q.push_back({2'd0, 8'h77});
        found = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (tx_start && !tx_ready) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_send_reach: found=%0b, want 1", found); end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({tx_start, tx_data, req_ready, grant_id, busy, timeout_err} !== {1'b0, 8'h00, 4'h0, 2'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_send_out: start=%0b data=%02h ready=%0h grant=%0d busy=%0b terr=%0b, want 0 00 0 3 0 0",
                     tx_start, tx_data, req_ready, grant_id, busy, timeout_err);
        end
        checks++;
        if (bytes_sent !== 4'd0) begin errors++; $display("FAIL rst_send_cnt: bytes_sent=%0d, want 0", bytes_sent); end
        reset = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rst_send_count: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if (o !== e) begin errors++; $display("FAIL rst_send_byte: got id%0d %02h, want id%0d %02h", o[9:8], o[7:0], e[9:8], e[7:0]); end
        end
    endtask

    task automatic test_enable_mask();
        bit ok;
        do_reset();
        req_enable = 4'b1011;
        rq[0].push_back({1'b1, 8'h20}); rq[1].push_back({1'b1, 8'h21});
        rq[2].push_back({1'b1, 8'h22}); rq[3].push_back({1'b1, 8'h23});
        exp_q.push_back({2'd0, 8'h20}); exp_q.push_back({2'd1, 8'h21}); exp_q.push_back({2'd3, 8'h23});
        wait_quiet(4'b1011, 800, ok);
        repeat (20) @(negedge clock);
        checks++;
        if (!ok) begin errors++; $display("FAIL enable_done: ok=%0b, want 1", ok); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL enable_count: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if (o !== e) begin errors++; $display("FAIL enable_byte: got id%0d %02h, want id%0d %02h", o[9:8], o[7:0], e[9:8], e[7:0]); end
        end
        checks++;
        if (rq[2].size() != 1 || grant_id !== 2'd3 || busy !== 1'b0) begin
            errors++; $display("FAIL enable_skip: req2 left=%0d grant=%0d busy=%0b, want 1 3 0", rq[2].size(), grant_id, busy);
        end
    endtask

    task automatic test_count_wrap();
        bit ok;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            rq[0].push_back({1'b1, 8'(8'h40 + i)});
            exp_q.push_back({2'd0, 8'(8'h40 + i)});
        end
        wait_quiet(4'hF, 3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_done: ok=%0b, want 1", ok); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL wrap_count: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if (o !== e) begin errors++; $display("FAIL wrap_byte: got id%0d %02h, want id%0d %02h", o[9:8], o[7:0], e[9:8], e[7:0]); end
        end
        checks++;
        if (bytes_sent !== 4'd1) begin errors++; $display("FAIL wrap_value: bytes_sent=%0d, want 1", bytes_sent); end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        req_enable = '1;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_back_to_back();
        test_timeout();
        test_reset_mid_send();
        test_enable_mask();
        test_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters (e.g. CPU debug port, memory dump engine, status reporter).
- Uses round-robin arbitration with packet lock: once a requester is granted, it keeps the transmitter until the byte flagged last has been handed over.
- Sequences the transmitter's tx_start/tx_data/ready interface and exposes grant and status outputs for the MMIO layer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 1024, max cycles spent waiting in FETCH for a locked requester's next byte; 0 disables the timeout.
- CNT_W, 16, width of the bytes_sent counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the final byte of its packet
- req_enable  in  NUM_REQ  requester enable mask
- req_ready  out  NUM_REQ  byte taken when req_valid & req_ready
- tx_ready  in  1  transmitter ready (high in IDLE or STOP)
- tx_start  out  1  registered start request to the transmitter
- tx_data  out  8  registered byte to the transmitter
- grant_id  out  clog2(NUM_REQ)  current or last granted requester
- busy  out  1  high in any state other than ARB
- timeout_err  out  1  one-cycle pulse when a lock is released by timeout
- bytes_sent  out  CNT_W  count of bytes accepted by the transmitter; wraps

Behaviour:
- Reset is synchronous, active-high, on clock; shared with the transmitter.
- Reset values: state=ARB, tx_start=0, tx_data=0, req_ready=0, grant_id=NUM_REQ-1 (so requester 0 has first priority), busy=0, timeout_err=0, bytes_sent=0, timeout count=0, tx_ready_q=1.
- tx_ready_q is a one-cycle register of tx_ready.
- Byte acceptance by the transmitter: accept = tx_start & tx_ready_q & ~tx_ready, i.e. the falling edge of ready while start is held.
  - This covers both transmitter cases: start from IDLE (accepted next cycle) and start from STOP (accepted only on a uart_tick).
- tx_start and tx_data are held stable until accept.
- State machine ARB -> FETCH -> SEND:
  - ARB:
    - Candidates are requesters with req_valid & req_enable.
    - Search starts at (grant_id+1) mod NUM_REQ, incrementing and wrapping.
    - On a hit: grant_id=winner, go to FETCH.
    - No candidate: stay in ARB.
  - FETCH:
    - req_ready[grant_id] is high combinationally; all other req_ready bits are low.
    - On req_valid[grant_id]: capture req_data into tx_data, capture req_last into hold_last, set timeout count=0, go to SEND.
    - If req_enable[grant_id] is low: go to ARB, no byte taken, no error.
    - Otherwise increment the timeout count. When it reaches LOCK_TIMEOUT (LOCK_TIMEOUT>0): pulse timeout_err, go to ARB.
  - SEND:
    - tx_start=1.
    - On accept: tx_start=0 next cycle, bytes_sent+1.
    - Then go to ARB if hold_last is set, otherwise back to FETCH (lock retained).
- Latency:
  - ARB to FETCH: 1 cycle. FETCH capture to tx_start high: 1 cycle.
  - With the transmitter idle, the start bit is entered 1 cycle after tx_start rises.
- Packets from different requesters never interleave, except after a timeout or disable release.
- Changing req_enable during SEND does not abort the byte in flight.
- Transfer width is fixed at 8 bits. bytes_sent wraps from 2^CNT_W-1 to 0.
- Simultaneous accept and reset: reset wins; the byte is not counted.
- Reset mid-SEND: controller and transmitter both return to idle and the byte is dropped. The requester must resend it.

Test Plan:
- Req0 sends 0x55 with last=1, transmitter idle -> req_ready[0] high 1 cycle; tx_start high with tx_data=0x55 until tx_ready falls; start bit then 0x55 on the line LSB first; bytes_sent=1; grant_id=0; busy low afterwards.
- All four requesters valid with single-byte packets 0x10, 0x11, 0x12, 0x13, refilled after each send -> line order 0x10, 0x11, 0x12, 0x13, 0x10; grant_id sequence 0, 1, 2, 3, 0.
- Req1 sends packet 0xA1, 0xA2, 0xA3 (last on 0xA3) while req2 is valid throughout -> no req2 byte before 0xA3 is accepted, then req2 is granted.
- Back-to-back: second byte's tx_start rises while the transmitter is in STOP -> tx_start held and tx_data stable until the uart_tick edge; exactly one accept; no gap beyond the single stop bit.
- LOCK_TIMEOUT=8: req0 sends 0x01 with last=0 then drops valid; req3 valid with 0x33 -> timeout_err pulses after 8 FETCH cycles, then 0x33 is sent.
- Reset asserted mid-SEND -> all outputs at reset values next cycle. With req_enable=4'b1011 and all valid, requester 2 is never granted.
